// File: rtl/multiplicador_param_if.sv
// Handshake and operand/result bundle for the sequential add-and-shift multiplier.
interface multiplicador_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   St;
    logic                   Sgn;
    logic [WIDTH-1:0]       Multiplicando;
    logic [WIDTH-1:0]       Multiplicador;
    logic [2*WIDTH-1:0]     Produto;
    logic                   Idle;
    logic                   Done;

    modport master (
        output St, Sgn, Multiplicando, Multiplicador,
        input  Produto, Idle, Done
    );

    modport slave (
        input  St, Sgn, Multiplicando, Multiplicador,
        output Produto, Idle, Done
    );
endinterface

// File: rtl/multiplicador_param.sv
// Sequential WIDTH-cycle add-and-shift multiplier, unsigned or two's-complement per request.
// The product accumulator drives Produto directly; Idle/Done are registered state flags.
module multiplicador_param #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    multiplicador_param_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic               sgn_q, sgn_n;
    logic               idle_q, done_q;

    logic [WIDTH:0]     upper_ext;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

    // Extend to WIDTH+1 bits; sum[WIDTH] is the carry (unsigned) or the true sign (signed).
    always_comb begin
        upper_ext = sgn_q ? {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
        a_ext     = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        addend    = acc[0] ? a_ext : '0;
        // Signed multiplier bit WIDTH-1 carries negative weight, hence the final subtract.
        if (sgn_q && (cnt == '0)) begin
            sum = upper_ext - addend;
        end else begin
            sum = upper_ext + addend;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        a_n     = a_q;
        sgn_n   = sgn_q;
        case (state)
            IDLE: begin
                if (bus.St) begin
                    a_n     = bus.Multiplicando;
                    sgn_n   = bus.Sgn;
                    acc_n   = {{WIDTH{1'b0}}, bus.Multiplicador};
                    cnt_n   = CW'(WIDTH - 1);
                    state_n = RUN;
                end
            end
            RUN: begin
                acc_n = {sum, acc[WIDTH-1:1]};
                cnt_n = cnt - CW'(1);
                if (cnt == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            a_q    <= '0;
            sgn_q  <= 1'b0;
            idle_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            a_q    <= a_n;
            sgn_q  <= sgn_n;
            idle_q <= (state_n == IDLE);
            done_q <= (state_n == DONE);
        end
    end

    assign bus.Produto = acc;
    assign bus.Idle    = idle_q;
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_multiplicador_param.sv
// Scoreboard bench for multiplicador_param at WIDTH=4 with hand-computed directed products.
module tb_multiplicador_param;
    localparam int unsigned W = 4;

    typedef struct packed {
        logic [2*W-1:0] prod;
        int unsigned    cyc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic        prev_done = 1'b0;

    multiplicador_param_if #(.WIDTH(W)) bus ();

    multiplicador_param #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pop expected product and completion cycle on every Done.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("reset_hold_outputs", {bus.Idle, bus.Done, bus.Produto}, {1'b1, 1'b0, 8'h00});
            prev_done <= 1'b0;
        end else begin
            if (prev_done) check("idle_after_done", 32'(bus.Idle), 32'd1);
            if (bus.Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("produto", 32'(bus.Produto), 32'(e.prod));
                    check("done_cycle", cyc, e.cyc);
                    check("idle_low_in_done", 32'(bus.Idle), 32'd0);
                end
            end
            prev_done <= bus.Done;
        end
    end

    // Called at a negedge; waits for Idle, presents one request for one cycle.
    task automatic do_mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] prod);
        int guard = 0;
        while (!bus.Idle && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        if (!bus.Idle) check("wait_idle_timeout", 32'd0, 32'd1);
        bus.St = 1'b1;
        bus.Sgn = sgn;
        bus.Multiplicando = a;
        bus.Multiplicador = b;
        sb.push_back('{prod: prod, cyc: cyc + 1 + W});
        @(negedge Clk);
        bus.St = 1'b0;
    endtask

    initial begin
        bus.St = 1'b0;
        bus.Sgn = 1'b0;
        bus.Multiplicando = '0;
        bus.Multiplicador = '0;

        // Reset held with St active must not start anything.
        #12 bus.St = 1'b1;
        #10 bus.St = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_idle", 32'(bus.Idle), 32'd1);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_produto", 32'(bus.Produto), 32'd0);

        // Directed vectors: {sgn, A, B, product}
        do_mul(1'b0, 4'd13, 4'd11, 8'h8F);
        do_mul(1'b0, 4'hF,  4'hF,  8'hE1);
        do_mul(1'b1, 4'hF,  4'hF,  8'h01);
        do_mul(1'b1, 4'h8,  4'h7,  8'hC8);
        do_mul(1'b1, 4'h8,  4'h8,  8'h40);
        do_mul(1'b1, 4'h5,  4'hD,  8'hF1);
        do_mul(1'b0, 4'h0,  4'h9,  8'h00);
        do_mul(1'b1, 4'h7,  4'h0,  8'h00);
        do_mul(1'b0, 4'h9,  4'h0,  8'h00);
        do_mul(1'b1, 4'h7,  4'h7,  8'h31);
        do_mul(1'b0, 4'h8,  4'h8,  8'h40);
        do_mul(1'b1, 4'h1,  4'h8,  8'hF8);
        do_mul(1'b1, 4'h8,  4'h1,  8'hF8);
        do_mul(1'b0, 4'h1,  4'hF,  8'h0F);
        do_mul(1'b1, 4'hF,  4'h7,  8'hF9);

        // St held high: one accept every W+2 cycles, operands refreshed just before each.
        while (!bus.Idle) @(negedge Clk);
        bus.St = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] a, b;
            logic [2*W-1:0] p;
            logic s;
            case (k)
                0: begin s = 1'b0; a = 4'h2; b = 4'h3; p = 8'h06; end
                1: begin s = 1'b1; a = 4'h3; b = 4'hE; p = 8'hFA; end
                2: begin s = 1'b0; a = 4'hA; b = 4'hC; p = 8'h78; end
                default: begin s = 1'b1; a = 4'hC; b = 4'hC; p = 8'h10; end
            endcase
            bus.Sgn = s;
            bus.Multiplicando = a;
            bus.Multiplicador = b;
            sb.push_back('{prod: p, cyc: cyc + 1 + W});
            repeat (W + 2) @(negedge Clk);
        end
        bus.St = 1'b0;

        // Inputs toggled during RUN/DONE must be ignored: single Done with 3*5.
        do_mul(1'b0, 4'h3, 4'h5, 8'h0F);
        for (int k = 0; k < W; k++) begin
            bus.St = 1'b1;
            bus.Sgn = k[0];
            bus.Multiplicando = 4'(k + 9);
            bus.Multiplicador = 4'(k + 6);
            @(negedge Clk);
        end
        bus.St = 1'b0;
        repeat (6) @(negedge Clk);

        // Asynchronous reset mid-RUN aborts with no Done.
        do_mul(1'b0, 4'h7, 4'h7, 8'h31);
        #2 Reset = 1'b0;
        #1;
        check("async_rst_idle", 32'(bus.Idle), 32'd1);
        check("async_rst_done", 32'(bus.Done), 32'd0);
        check("async_rst_produto", 32'(bus.Produto), 32'd0);
        void'(sb.pop_back());
        repeat (3) @(negedge Clk);
        bus.St = 1'b1;
        bus.Sgn = 1'b0;
        bus.Multiplicando = 4'h6;
        bus.Multiplicador = 4'h7;
        Reset = 1'b1;
        sb.push_back('{prod: 8'h2A, cyc: cyc + 1 + W});
        @(negedge Clk);
        bus.St = 1'b0;

        // Drain with a bounded wait.
        for (int g = 0; g < 100 && sb.size() != 0; g++) @(negedge Clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
